// File: rtl/seq_divider_2n.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes one edge after acceptance.
module seq_divider_2n #(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] P,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Q,
    output logic [N-1:0]   R,
    output logic           dbz,
    output logic [1:0]     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and the result
    // holds there until the consumer raises out_ready.

    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [2*N-1:0] quo;
    logic [N:0]     rem;
    logic [N-1:0]   div;
    logic [CW-1:0]  cnt;
    logic           dbz_r;

    logic           accept;
    logic           last_step;
    logic [N:0]     rem_sh;
    logic [N+1:0]   diff;
    logic           step_ok;

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (cnt == CW'(1));

    // One restoring step; a bit shifted out of the remainder means the
    // shifted value exceeds any N-bit divisor, so the subtraction must succeed.
    always_comb begin
        rem_sh  = {rem[N-1:0], quo[2*N-1]};
        diff    = {1'b0, rem_sh} - {2'b00, div};
        step_ok = rem[N] | ~diff[N+1];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = (B == '0) ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operands are captured once, so later input changes cannot leak in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo   <= '0;
            rem   <= '0;
            div   <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            quo   <= P;
            rem   <= '0;
            div   <= B;
            cnt   <= CW'(2*N);
            dbz_r <= (B == '0);
`ifdef DIV_ZERO_FAST_EN
            if (B == '0) begin
                quo <= '1;
                rem <= {1'b0, P[N-1:0]};
                cnt <= '0;
            end
`endif
        end else if (state == RUN) begin
            rem <= step_ok ? diff[N:0] : rem_sh;
            quo <= {quo[2*N-2:0], step_ok};
            cnt <= cnt - CW'(1);
        end
    end

    // Output logic: results are masked to zero outside DONE
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        Q         = '0;
        R         = '0;
        dbz       = 1'b0;
        if (state == DONE) begin
            Q   = quo;
            R   = rem[N-1:0];
            dbz = dbz_r;
        end
        dbg_state = state;
    end

endmodule

// File: tb/tb_seq_divider_2n.sv
// Self-checking bench for seq_divider_2n (N=2): directed scenarios plus an exhaustive operand sweep.
module tb_seq_divider_2n;

    localparam int N   = 2;
    localparam int LAT = 2*N+1;
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 2*N+1;
`endif
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] P;
    logic [1:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Q;
    logic [1:0] R;
    logic       dbz;
    logic [1:0] dbg_state;

    logic [6:0] exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    seq_divider_2n #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .dbz       (dbz),
        .dbg_state (dbg_state)
    );

    // Reference result packed as {Q, R, dbz}
    function automatic logic [6:0] model(input logic [3:0] p, input logic [1:0] b);
        logic [3:0] q;
        logic [3:0] r4;
        if (b == 2'd0) begin
            q  = 4'hF;
            r4 = {2'b00, p[1:0]};
        end else begin
            q  = p / {2'b00, b};
            r4 = p % {2'b00, b};
        end
        return {q, r4[1:0], (b == 2'd0)};
    endfunction

    task automatic drive_op(input logic [3:0] p, input logic [1:0] b);
        P        = p;
        B        = b;
        in_valid = 1'b1;
        exp_q.push_back(model(p, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts edges from the accepting edge (inclusive) until out_valid is seen
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if ({in_ready, out_valid, Q, R, dbz, dbg_state} !== {1'b1, 1'b0, 4'h0, 2'h0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_async: got rdy=%b vld=%b Q=%h R=%h dbz=%b st=%0d expected rdy=1 vld=0 Q=0 R=0 dbz=0 st=0",
                     in_ready, out_valid, Q, R, dbz, dbg_state);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        int         lat;
        logic [6:0] exp;
        drive_op(4'd9, 2'd3);
        tests_run++;
        if ({in_ready, out_valid, Q, R, dbz} !== 9'b0) begin
            tests_failed++;
            $display("FAIL basic_run_outputs: got rdy=%b vld=%b Q=%h R=%h dbz=%b expected all 0",
                     in_ready, out_valid, Q, R, dbz);
        end
        wait_out(lat);
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
        end
        exp = exp_q.pop_front();
        tests_run++;
        if ({Q, R, dbz} !== exp) begin
            tests_failed++;
            $display("FAIL basic_result: got %h expected %h", {Q, R, dbz}, exp);
        end
        take();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure;
        int         lat;
        logic [6:0] exp;
        drive_op(4'd15, 2'd2);
        wait_out(lat);
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
        end
        exp = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({out_valid, Q, R, dbz} !== {1'b1, exp}) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got vld=%b res=%h expected vld=1 res=%h", i, out_valid, {Q, R, dbz}, exp);
            end
            @(posedge clk); #1;
        end
        take();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_div_zero;
        int         lat;
        logic [6:0] exp;
        drive_op(4'd5, 2'd0);
        wait_out(lat);
        tests_run++;
        if (lat !== LAT_Z) begin
            tests_failed++;
            $display("FAIL dbz_latency: got %0d expected %0d", lat, LAT_Z);
        end
        exp = exp_q.pop_front();
        tests_run++;
        if ({Q, R, dbz} !== exp) begin
            tests_failed++;
            $display("FAIL dbz_result: got %h expected %h", {Q, R, dbz}, exp);
        end
        take();
    endtask

    task automatic test_ignore_inputs;
        int         lat;
        logic [6:0] exp;
        drive_op(4'd6, 2'd2);
        P        = 4'hF;
        B        = 2'd1;
        in_valid = 1'b1;
        wait_out(lat);
        in_valid = 1'b0;
        exp = exp_q.pop_front();
        tests_run++;
        if (lat !== LAT || {Q, R, dbz} !== exp) begin
            tests_failed++;
            $display("FAIL ignore_result: got lat=%0d res=%h expected lat=%0d res=%h", lat, {Q, R, dbz}, LAT, exp);
        end
        take();
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_no_phantom: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] ops_p[4];
        logic [1:0] ops_b[4];
        logic [6:0] exp;
        int         idx  = 0;
        int         got  = 0;
        int         last = 0;
        ops_p = '{4'd0, 4'd7, 4'd12, 4'd15};
        ops_b = '{2'd3, 2'd2, 2'd3, 2'd1};
        out_ready = 1'b1;
        for (int c = 0; c < 100 && got < 4; c++) begin
            if (out_valid) begin
                exp = exp_q.pop_front();
                tests_run++;
                if ({Q, R, dbz} !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b_result_%0d: got %h expected %h", got, {Q, R, dbz}, exp);
                end
                if (got > 0) begin
                    tests_run++;
                    if (c - last !== 2*N+2) begin
                        tests_failed++;
                        $display("FAIL b2b_period_%0d: got %0d expected %0d", got, c - last, 2*N+2);
                    end
                end
                last = c;
                got++;
            end
            if (in_ready && idx < 4) begin
                P        = ops_p[idx];
                B        = ops_b[idx];
                in_valid = 1'b1;
                exp_q.push_back(model(ops_p[idx], ops_b[idx]));
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (got !== 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results expected 4", got);
        end
    endtask

    task automatic test_abort;
        int         lat;
        int         seen = 0;
        logic [6:0] exp;
        P        = 4'd14;
        B        = 2'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, out_valid, Q, R, dbz, dbg_state} !== {1'b1, 1'b0, 4'h0, 2'h0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL abort_reset: got rdy=%b vld=%b Q=%h R=%h dbz=%b st=%0d expected rdy=1 vld=0 Q=0 R=0 dbz=0 st=0",
                     in_ready, out_valid, Q, R, dbz, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen);
        end
        drive_op(4'd14, 2'd3);
        wait_out(lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (lat !== LAT || {Q, R, dbz} !== exp) begin
            tests_failed++;
            $display("FAIL abort_next_op: got lat=%0d res=%h expected lat=%0d res=%h", lat, {Q, R, dbz}, LAT, exp);
        end
        take();
    endtask

    task automatic test_sweep;
        int         lat;
        int         hold;
        logic [6:0] exp;
        logic [5:0] recon;
        for (int p = 0; p < 16; p++) begin
            for (int b = 0; b < 4; b++) begin
                drive_op(4'(p), 2'(b));
                wait_out(lat);
                tests_run++;
                if (lat !== ((b == 0) ? LAT_Z : LAT)) begin
                    tests_failed++;
                    $display("FAIL sweep_latency p=%0d b=%0d: got %0d expected %0d", p, b, lat, (b == 0) ? LAT_Z : LAT);
                end
                exp = exp_q.pop_front();
                tests_run++;
                if ({Q, R, dbz} !== exp) begin
                    tests_failed++;
                    $display("FAIL sweep_result p=%0d b=%0d: got %h expected %h", p, b, {Q, R, dbz}, exp);
                end
                recon = {2'b00, Q} * 6'(b) + {4'b0000, R};
                tests_run++;
                if (b != 0) begin
                    if (recon !== 6'(p) || R >= 2'(b) || dbz !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL sweep_identity p=%0d b=%0d: got Q*B+R=%0d R=%0d dbz=%b expected %0d, R<%0d, dbz=0",
                                 p, b, recon, R, dbz, p, b);
                    end
                end else begin
                    if (Q !== 4'hF || R !== 2'(p) || dbz !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL sweep_zero p=%0d: got Q=%h R=%h dbz=%b expected Q=f R=%h dbz=1", p, Q, R, dbz, 2'(p));
                    end
                end
                hold = $urandom_range(0, 2);
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    tests_run++;
                    if ({out_valid, Q, R, dbz} !== {1'b1, exp}) begin
                        tests_failed++;
                        $display("FAIL sweep_hold p=%0d b=%0d: got vld=%b res=%h expected vld=1 res=%h",
                                 p, b, out_valid, {Q, R, dbz}, exp);
                    end
                end
                take();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        P         = '0;
        B         = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_div_zero();
        test_ignore_inputs();
        test_back_to_back();
        test_abort();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
